fp32_multiplier: RTL and testbench

- Sequential IEEE-754 single-precision multiplier. It is the inverse operation to the team's floating-point divider and shares its operand classification and exponent conventions.
- Uses a radix-4 shift-add mantissa datapath that retires 2 multiplier bits per cycle, then normalizes and rounds to nearest-even.
- Valid/ready handshake on both sides, so it can sit in the FPU issue path next to the divider.

---
 rtl/fp32_multiplier.sv | 190 +++++++++++++++++++
 tb/tb_fp32_multiplier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_multiplier.sv
// rtl/fp32_multiplier.sv - sequential binary32 multiplier, radix-4 shift-add, round-to-nearest-even
module fp32_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] output_z
);

    typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;

    state_t state, state_next;

    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mant_a_q;
    logic [23:0]        mb_q;
    logic [25:0]        acc_q;
    logic [23:0]        lo_q;
    logic [3:0]         cnt_q;
    logic [22:0]        mant_q;
    logic               guard_q;
    logic               sticky_q;

    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic        in_sign;
    logic        special;
    logic [31:0] special_z;
    logic signed [9:0] exp_in;

    assign a_exp  = input_a[30:23];
    assign b_exp  = input_b[30:23];
    assign a_frac = input_a[22:0];
    assign b_frac = input_b[22:0];
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
    assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign in_sign = input_a[31] ^ input_b[31];
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign exp_in  = signed'({2'b00, a_exp}) + signed'({2'b00, b_exp}) - 10'sd127;

    // Denormal operands count as zero, so inf times a denormal is also NaN.
    always_comb begin
        special_z = {in_sign, 31'd0};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_z = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            special_z = {in_sign, 8'hFF, 23'd0};
        end
    end

    logic [25:0] addend;
    logic [25:0] step_sum;
    logic [47:0] product;

    always_comb begin
        addend = 26'd0;
        case (mb_q[1:0])
            2'd1:    addend = {2'b00, mant_a_q};
            2'd2:    addend = {1'b0, mant_a_q, 1'b0};
            2'd3:    addend = {2'b00, mant_a_q} + {1'b0, mant_a_q, 1'b0};
            default: addend = 26'd0;
        endcase
    end

    assign step_sum = acc_q + addend;
    assign product  = {acc_q[23:0], lo_q};

    logic              round_up;
    logic              carry;
    logic [22:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [31:0]       round_z;

    assign round_up        = guard_q & (sticky_q | mant_q[0]);
    assign {carry, mant_r} = {1'b0, mant_q} + {23'd0, round_up};
    assign exp_r           = exp_q + signed'({9'd0, carry});

    always_comb begin
        round_z = {sign_q, exp_r[7:0], mant_r};
        if (exp_r >= 10'sd255) begin
            round_z = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            round_z = {sign_q, 31'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = special ? DONE : MULT;
                end
            end
            MULT: begin
                if (cnt_q == 4'd11) begin
                    state_next = NORM;
                end
            end
            NORM:  state_next = ROUND;
            ROUND: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Right-shifting accumulator: after 12 steps {acc[23:0], lo} holds the full product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mant_a_q <= 24'd0;
            mb_q     <= 24'd0;
            acc_q    <= 26'd0;
            lo_q     <= 24'd0;
            cnt_q    <= 4'd0;
            mant_q   <= 23'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            output_z <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= exp_in;
                        mant_a_q <= {1'b1, a_frac};
                        mb_q     <= {1'b1, b_frac};
                        acc_q    <= 26'd0;
                        lo_q     <= 24'd0;
                        cnt_q    <= 4'd0;
                        if (special) begin
                            output_z <= special_z;
                        end
                    end
                end
                MULT: begin
                    acc_q <= {2'b00, step_sum[25:2]};
                    lo_q  <= {step_sum[1:0], lo_q[23:2]};
                    mb_q  <= {2'b00, mb_q[23:2]};
                    cnt_q <= cnt_q + 4'd1;
                end
                NORM: begin
                    if (product[47]) begin
                        mant_q   <= product[46:24];
                        guard_q  <= product[23];
                        sticky_q <= |product[22:0];
                        exp_q    <= exp_q + 10'sd1;
                    end else begin
                        mant_q   <= product[45:23];
                        guard_q  <= product[22];
                        sticky_q <= |product[21:0];
                    end
                end
                ROUND: begin
                    output_z <= round_z;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb/tb_fp32_multiplier.sv - directed vectors checked against an integer rounding model
module tb_fp32_multiplier;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_z;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    fp32_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_a   (input_a),
        .input_b   (input_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .output_z  (output_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact integer product, then round-half-even on the discarded remainder.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e, sh;
        longint p, m, rem, half;
        logic   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p >= 64'h0000_8000_0000_0000) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        m    = p >> sh;
        rem  = p - (m << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && m[0])) m = m + 1;
        if (m == 64'h0000_0000_0100_0000) begin
            m = 64'h0000_0000_0080_0000;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_out actual=%08h required=none", output_z);
            end else begin
                if (output_z !== exp_q[0]) begin
                    failures++;
                    $display("FAIL output_z actual=%08h required=%08h", output_z, exp_q[0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit, input int lat);
        int n;
        check1("model_pin", model(a, b), lit);
        @(negedge clk);
        check1("accept_ready", {31'd0, in_ready}, 32'd1);
        input_a  = a;
        input_b  = b;
        in_valid = 1'b1;
        exp_q.push_back(lit);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check1("latency", n, lat);
    endtask

    task automatic finish_hs();
        @(posedge clk);
        #1;
        check1("hs_out_valid", {31'd0, out_valid}, 32'd0);
        check1("hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    localparam int NV = 17;
    logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'hC0000000, 32'h3FFFFFFF,
                             32'h3F800000, 32'h3F000000, 32'h7E800000, 32'h7F000000, 32'h7F000000,
                             32'h00800000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h80400000,
                             32'h00000000, 32'h80000000};
    logic [31:0] vb [NV] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h40400000, 32'h3FFFFFFF,
                             32'h00800000, 32'h00800000, 32'h40000000, 32'h40000000, 32'h7F000000,
                             32'h00800000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                             32'hFF800000, 32'h40000000};
    logic [31:0] vz [NV] = '{32'h40400000, 32'h3FC00002, 32'h3F800002, 32'hC0C00000, 32'h407FFFFE,
                             32'h00800000, 32'h00000000, 32'h7F000000, 32'h7F800000, 32'h7F800000,
                             32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
                             32'h7FC00000, 32'h80000000};
    int          vl [NV] = '{14, 14, 14, 14, 14, 14, 14, 14, 14, 14, 14, 0, 0, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        input_a   = 32'd0;
        input_b   = 32'd0;
        #2 rst = 1'b1;
        #1;
        check1("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check1("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check1("rst_output_z", output_z, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            send(va[i], vb[i], vz[i], vl[i]);
            finish_hs();
        end

        out_ready = 1'b0;
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 14);
        input_a  = 32'h40400000;
        input_b  = 32'h40000000;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check1("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check1("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check1("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check1("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check1("bp_no_accept", {31'd0, in_ready}, 32'd1);
        end

        @(negedge clk);
        input_a  = 32'h3FC00000;
        input_b  = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check1("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check1("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check1("abort_output_z", output_z, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(32'h40400000, 32'h40000000, 32'h40C00000, 14);
        finish_hs();

        repeat (2) @(negedge clk);
        check1("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
